// File: rtl/if_stage_pkg.sv
// Shared types for the instruction fetch slice: ID-stage payload, word helpers
// and the default fetch start address.
package if_stage_pkg;

  typedef logic [31:0] u32_t;

  typedef struct packed {
    u32_t ir;
    u32_t ia_plus_4;
  } id_params_t;

  localparam u32_t IA_RESET_DEFAULT = 32'h0000_0000;

  function automatic u32_t word_align(u32_t a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO used for both the fetched-word buffer and the queue
// of IA+4 values that belong to in-flight memory requests.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers wrap at DEPTH so non-power-of-two depths work too.
  function automatic logic [AW-1:0] next_ptr(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: issues in-order word reads, pairs each returned word with
// its IA+4, buffers the pair for ID and redirects on a taken branch from ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter u32_t        RESET_IA = IA_RESET_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req_valid,
  input  logic       imem_req_ready,
  output u32_t       imem_addr,
  input  logic       imem_rsp_valid,
  input  u32_t       imem_rsp_data,
  output id_params_t id_params,
  output logic       id_valid,
  input  logic       id_ready,
  input  logic       branch_req,
  input  u32_t       branch_ia
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  u32_t          ia;
  u32_t          pend_head;
  id_params_t    fifo_head;
  id_params_t    fifo_in;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] drop_cnt;
  logic [SW-1:0] credit_used;
  logic          pop;
  logic          take;
  logic          accept;
  logic          keep_rsp;

  assign pop    = id_valid && id_ready;
  assign take   = pop && branch_req;
  assign accept = imem_req_valid && imem_req_ready;

  // Outstanding plus buffered words may never exceed DEPTH, which is what keeps
  // the data FIFO from overflowing without any back-pressure on memory.
  assign credit_used    = SW'(out_cnt) + SW'(fifo_count) - SW'(pop);
  assign imem_req_valid = rst_n && !take && (credit_used < SW'(DEPTH));
  assign imem_addr      = word_align(ia);

  assign id_valid  = rst_n && (fifo_count != '0);
  assign id_params = rst_n ? fifo_head : '0;

  assign keep_rsp = imem_rsp_valid && (drop_cnt == '0);
  assign fifo_in  = '{ir: imem_rsp_data, ia_plus_4: pend_head};

  // The pending queue's occupancy is the outstanding-request count.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pend_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (ia + 32'd4),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head      (pend_head),
    .count     (out_cnt)
  );

  fetch_fifo #(
    .WIDTH ($bits(id_params_t)),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep_rsp),
    .push_data (fifo_in),
    .pop       (pop),
    .flush     (take),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ia       <= RESET_IA;
      drop_cnt <= '0;
    end else begin
      if (take) begin
        ia <= word_align(branch_ia);
      end else if (accept) begin
        ia <= ia + 32'd4;
      end

      // Everything still in flight after this cycle belongs to the wrong path.
      if (take) begin
        drop_cnt <= out_cnt - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  rsp_needs_request: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (out_cnt != '0)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: accepted requests queue expected ID payloads,
// a negedge monitor pops and compares them, directed checks cover timing cases.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req_valid;
  logic       imem_req_ready;
  u32_t       imem_addr;
  logic       imem_rsp_valid;
  u32_t       imem_rsp_data;
  id_params_t id_params;
  logic       id_valid;
  logic       id_ready;
  logic       branch_req;
  u32_t       branch_ia;

  logic       w_req_valid;
  u32_t       w_addr;
  id_params_t w_params;
  logic       w_id_valid;

  always #5 clk = ~clk;

  if_stage #(.RESET_IA(IA_RESET_DEFAULT), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_params      (id_params),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .branch_req     (branch_req),
    .branch_ia      (branch_ia)
  );

  // Second instance only exercises the address wrap at the top of memory.
  if_stage #(.RESET_IA(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (1'b1),
    .imem_addr      (w_addr),
    .imem_rsp_valid (1'b0),
    .imem_rsp_data  (32'h0),
    .id_params      (w_params),
    .id_valid       (w_id_valid),
    .id_ready       (1'b0),
    .branch_req     (1'b0),
    .branch_ia      (32'h0)
  );

  typedef struct {
    u32_t addr;
    int   due;
  } mreq_t;

  mreq_t      mq[$];
  id_params_t exp_id[$];
  u32_t       exp_next;
  int         cyc;
  int         mem_lat;
  logic       mem_ready;
  int         checks;
  int         failures;
  int         pops;
  int         accepts;
  u32_t       last_acc_addr;
  id_params_t last_pop;

  assign imem_req_ready = mem_ready;

  function automatic u32_t mem_word(u32_t a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // In-order memory: answers each accepted request mem_lat cycles later.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cyc            = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (!rst_n) begin
        mq.delete();
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  end

  // Monitor: request addresses against the bench's own address model, ID
  // output against the queue of expected payloads.
  initial begin
    exp_next = IA_RESET_DEFAULT;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_id.delete();
        mq.delete();
        exp_next = IA_RESET_DEFAULT;
      end else begin
        if (id_valid && id_ready) begin
          pops++;
          last_pop = id_params;
          if (exp_id.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL id_unexpected got=%h expected=none", id_params);
          end else begin
            check("id_params", id_params, exp_id.pop_front());
          end
          if (branch_req) begin
            check("no_req_on_take", 64'(imem_req_valid), 64'(0));
            exp_id.delete();
            exp_next = branch_ia & 32'hFFFF_FFFC;
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          accepts++;
          last_acc_addr = imem_addr;
          check("req_addr", imem_addr, exp_next);
          exp_id.push_back('{ir: mem_word(exp_next), ia_plus_4: exp_next + 32'd4});
          mq.push_back('{addr: imem_addr, due: cyc + mem_lat});
          exp_next = exp_next + 32'd4;
        end
      end
    end
  end

  task automatic expect_next_accept(string name, u32_t exp_addr);
    int  n0   = accepts;
    bit  seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (accepts != n0) begin
        seen = 1'b1;
        check({name, "_addr"}, last_acc_addr, exp_addr);
        check({name, "_latency"}, 64'(i), 64'(0));
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_request expected=%h", name, exp_addr);
    end
  endtask

  task automatic expect_next_pop(string name, u32_t exp_ia4);
    int n0   = pops;
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pops != n0) begin
        seen = 1'b1;
        check(name, last_pop.ia_plus_4, exp_ia4);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_pop expected=%h", name, exp_ia4);
    end
  endtask

  task automatic redirect_on(string name, u32_t match, u32_t target,
                             u32_t exp_req, u32_t exp_ia4);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (id_valid && id_params.ia_plus_4 == match) begin
        branch_req = 1'b1;
        branch_ia  = target;
        found      = 1'b1;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_head_timeout got=absent expected=%h", name, match);
    end
    tick();
    branch_req = 1'b0;
    expect_next_accept(name, exp_req);
    expect_next_pop({name, "_first_id"}, exp_ia4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    u32_t held;
    checks     = 0;
    failures   = 0;
    pops       = 0;
    accepts    = 0;
    rst_n      = 1'b0;
    id_ready   = 1'b0;
    branch_req = 1'b0;
    branch_ia  = '0;
    mem_ready  = 1'b1;
    mem_lat    = 1;

    // Reset values and streaming at 1-cycle latency.
    repeat (3) tick();
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'(0));
    check("rst_id_valid", 64'(id_valid), 64'(0));
    check("rst_id_params", id_params, 64'(0));
    check("rst_wrap_params", w_params, 64'(0));
    tick();
    rst_n    = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    check("first_req_valid", 64'(imem_req_valid), 64'(1));
    check("first_req_addr", imem_addr, 32'h0);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    check("fill_c0", 64'(id_valid), 64'(0));
    tick();
    @(negedge clk);
    check("fill_c1", 64'(id_valid), 64'(0));
    check("wrap_second_valid", 64'(w_req_valid), 64'(1));
    check("wrap_second_addr", w_addr, 32'h0);
    tick();
    @(negedge clk);
    check("fill_c2", 64'(id_valid), 64'(1));
    check("fill_c2_ia4", id_params.ia_plus_4, 32'h4);
    check("wrap_credit_stop", 64'(w_req_valid), 64'(0));
    #1;
    n0 = pops;
    repeat (8) tick();
    @(negedge clk);
    #1;
    check("throughput_pops", 64'(pops - n0), 64'(8));

    // ID stalled from reset: only DEPTH requests may go out.
    do_reset();
    id_ready = 1'b0;
    n0 = accepts;
    repeat (4) tick();
    @(negedge clk);
    #1;
    check("stall_accepts", 64'(accepts - n0), 64'(DEPTH));
    check("stall_req_valid", 64'(imem_req_valid), 64'(0));
    check("stall_id_valid", 64'(id_valid), 64'(1));
    tick();
    id_ready = 1'b1;
    repeat (10) tick();

    // Redirects with words still in flight at 4-cycle latency.
    do_reset();
    mem_lat  = 4;
    id_ready = 1'b1;
    redirect_on("redir_100", 32'h8, 32'h100, 32'h100, 32'h104);
    redirect_on("redir_203", 32'h10C, 32'h203, 32'h200, 32'h204);

    // Memory back-pressure: address must hold while not accepted.
    tick();
    mem_ready = 1'b0;
    held      = imem_addr;
    n0        = accepts;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_addr", imem_addr, held);
      tick();
    end
    check("hold_no_accept", 64'(accepts - n0), 64'(0));
    mem_ready = 1'b1;
    mem_lat   = 4;
    repeat (25) tick();

    // Reset with a full FIFO.
    mem_lat  = 1;
    id_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("full_id_valid", 64'(id_valid), 64'(1));
    check("full_no_req", 64'(imem_req_valid), 64'(0));
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_id_valid", 64'(id_valid), 64'(0));
    check("midrst_req_valid", 64'(imem_req_valid), 64'(0));
    tick();
    @(negedge clk);
    check("midrst_next_id_valid", 64'(id_valid), 64'(0));
    check("midrst_next_req_valid", 64'(imem_req_valid), 64'(0));
    tick();
    rst_n    = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    check("post_rst_req_valid", 64'(imem_req_valid), 64'(1));
    check("post_rst_addr", imem_addr, 32'h0);
    repeat (10) tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
